// File: rtl/eq2_run_pkg.sv
// Shared types and constants for the 2-bit equal-run detector.
package eq2_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam int unsigned DEF_RUN_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned RUN_CNT_W   = 8;

endpackage

// File: rtl/eq2_cmp.sv
// Purely combinational 2-bit equality compare.
module eq2_cmp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

// File: rtl/eq2_run_detector.sv
// Counts consecutive accepted samples with a==b; raises a hit event with
// valid/ready hand-off after RUN_LEN in a row and keeps a saturating hit count.
// Build option: define EQ2_RUN_OVERLAP_EN so a hand-off resumes at RUN_LEN-1,
// letting every further equal sample produce another hit.
module eq2_run_detector
  import eq2_run_pkg::*;
#(
  parameter int unsigned RUN_LEN = DEF_RUN_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           a,
  input  logic [1:0]           b,
  output logic                 eq_q,
  output logic [RUN_CNT_W-1:0] run_cnt,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic [CNT_W-1:0]     hit_count
);

  localparam logic [RUN_CNT_W-1:0] RUN_LEN_C = RUN_CNT_W'(RUN_LEN);

  state_t               state, state_n;
  logic [RUN_CNT_W-1:0] run_cnt_n, run_inc;
  logic                 eq_n;
  logic [CNT_W-1:0]     hit_count_n;
  logic                 eq;
  logic                 accept;

  eq2_cmp u_cmp (
    .a  (a),
    .b  (b),
    .eq (eq)
  );

  // Samples are blocked while a hit is pending, so a hand-off never overlaps an accept.
  assign in_ready  = (state != HIT);
  assign hit_valid = (state == HIT);
  assign accept    = in_valid && in_ready;
  assign run_inc   = run_cnt + 1'b1;

  // State and datapath registers; reset beats everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      run_cnt   <= '0;
      eq_q      <= 1'b0;
      hit_count <= '0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_cnt_n;
      eq_q      <= eq_n;
      hit_count <= hit_count_n;
    end
  end

  // Next-state logic: clear first, then accept in IDLE/RUN or hand-off in HIT.
  always_comb begin
    state_n     = state;
    run_cnt_n   = run_cnt;
    eq_n        = eq_q;
    hit_count_n = hit_count;
    if (clr) begin
      state_n     = IDLE;
      run_cnt_n   = '0;
      eq_n        = 1'b0;
      hit_count_n = '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            eq_n = eq;
            if (eq) begin
              // run_cnt is 0 in IDLE, so the same increment covers both states
              run_cnt_n = run_inc;
              state_n   = (run_inc == RUN_LEN_C) ? HIT : RUN;
            end else begin
              run_cnt_n = '0;
              state_n   = IDLE;
            end
          end
        end
        HIT: begin
          if (hit_ready) begin
            if (hit_count != {CNT_W{1'b1}}) hit_count_n = hit_count + 1'b1;
`ifdef EQ2_RUN_OVERLAP_EN
            state_n   = RUN;
            run_cnt_n = RUN_LEN_C - 1'b1;
`else
            state_n   = IDLE;
            run_cnt_n = '0;
`endif
          end
        end
        default: begin
          state_n   = IDLE;
          run_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq2_run_detector.sv
// Directed self-checking bench for eq2_run_detector (RUN_LEN=4, CNT_W=8).
// Expectations follow the build: define EQ2_RUN_OVERLAP_EN for both files together.
module tb_eq2_run_detector;

  logic       clk = 1'b0;
  logic       reset_n, clr, in_valid, in_ready, eq_q, hit_valid, hit_ready;
  logic [1:0] a, b;
  logic [7:0] run_cnt, hit_count;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  eq2_run_detector #(.RUN_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .eq_q      (eq_q),
    .run_cnt   (run_cnt),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_count (hit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with toggling inputs
    reset_n = 1'b0; clr = 1'b1; in_valid = 1'b1; hit_ready = 1'b1; a = 2'b01; b = 2'b01;
    tick();
    a = 2'b10; clr = 1'b0;
    tick();
    chk("rst_eq_q", 32'(eq_q), 0);
    chk("rst_run_cnt", 32'(run_cnt), 0);
    chk("rst_hit_valid", 32'(hit_valid), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    reset_n = 1'b1; in_valid = 1'b0; hit_ready = 1'b0;
    tick();
    chk("idle_run_cnt", 32'(run_cnt), 0);

    // four equal samples, event held under backpressure
    in_valid = 1'b1; a = 2'b01; b = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("run_up", 32'(run_cnt), 32'(i));
      chk("run_up_nohit", 32'(hit_valid), 0);
    end
    tick();
    chk("hit_run_cnt", 32'(run_cnt), 4);
    chk("hit_valid_latency", 32'(hit_valid), 1);
    chk("hit_in_ready", 32'(in_ready), 0);
    chk("hit_eq_q", 32'(eq_q), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hit_hold_valid", 32'(hit_valid), 1);
      chk("hit_hold_cnt", 32'(run_cnt), 4);
      chk("hit_hold_count", 32'(hit_count), 0);
    end
    in_valid = 1'b0; hit_ready = 1'b1;
    tick();
    chk("handoff_count", 32'(hit_count), 1);
    chk("handoff_in_ready", 32'(in_ready), 1);
`ifdef EQ2_RUN_OVERLAP_EN
    chk("handoff_run_cnt", 32'(run_cnt), 3);
`else
    chk("handoff_run_cnt", 32'(run_cnt), 0);
`endif
    chk("handoff_valid", 32'(hit_valid), 0);
    hit_ready = 1'b0;
    tick();
    chk("no_repeat_count", 32'(hit_count), 1);

    // soft clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_run_cnt", 32'(run_cnt), 0);
    chk("clr_hit_count", 32'(hit_count), 0);
    chk("clr_eq_q", 32'(eq_q), 0);

    // eq, eq, eq, neq, eq
    in_valid = 1'b1; a = 2'b10; b = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("pat_run", 32'(run_cnt), 32'(i));
    end
    b = 2'b11;
    tick();
    chk("pat_neq_cnt", 32'(run_cnt), 0);
    chk("pat_neq_eq_q", 32'(eq_q), 0);
    b = 2'b10;
    tick();
    chk("pat_restart", 32'(run_cnt), 1);
    chk("pat_nohit", 32'(hit_valid), 0);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // accepts separated by 3-cycle gaps with unequal data on the bus
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; a = 2'b11; b = 2'b11;
      tick();
      chk("gap_accept", 32'(run_cnt), 32'(i));
      if (i < 4) begin
        in_valid = 1'b0; a = 2'b00; b = 2'b01;
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("gap_hold_cnt", 32'(run_cnt), 32'(i));
          chk("gap_hold_eq", 32'(eq_q), 1);
        end
      end
    end
    chk("gap_hit", 32'(hit_valid), 1);
    in_valid = 1'b0;

    // clear wins over hand-off in HIT
    clr = 1'b1; hit_ready = 1'b1;
    tick();
    clr = 1'b0; hit_ready = 1'b0;
    chk("clrhit_valid", 32'(hit_valid), 0);
    chk("clrhit_run_cnt", 32'(run_cnt), 0);
    chk("clrhit_count", 32'(hit_count), 0);
    chk("clrhit_in_ready", 32'(in_ready), 1);

    // continuous stream with hit_ready held high
    in_valid = 1'b1; hit_ready = 1'b1; a = 2'b01; b = 2'b01;
    tick(); tick(); tick(); tick();
    chk("str_hit1", 32'(hit_valid), 1);
    tick();
    chk("str_count1", 32'(hit_count), 1);
`ifdef EQ2_RUN_OVERLAP_EN
    chk("ovl_run_cnt", 32'(run_cnt), 3);
    tick();
    chk("ovl_hit2", 32'(hit_valid), 1);
    chk("ovl_hit2_cnt", 32'(run_cnt), 4);
    tick();
    chk("ovl_count2", 32'(hit_count), 2);
    tick();
    chk("ovl_hit3", 32'(hit_valid), 1);
    tick();
    chk("ovl_count3", 32'(hit_count), 3);
`else
    chk("novl_run_cnt", 32'(run_cnt), 0);
    tick();
    chk("novl_restart", 32'(run_cnt), 1);
    chk("novl_nohit", 32'(hit_valid), 0);
`endif

    // saturation of hit_count
    for (int i = 0; i < 3000 && hit_count != 8'hFF; i++) tick();
    chk("sat_reach", 32'(hit_count), 32'hFF);
    for (int i = 0; i < 12; i++) tick();
    chk("sat_hold", 32'(hit_count), 32'hFF);

    // reset beats clr and traffic
    reset_n = 1'b0; clr = 1'b1;
    tick();
    chk("rst2_hit_count", 32'(hit_count), 0);
    chk("rst2_in_ready", 32'(in_ready), 1);
    chk("rst2_run_cnt", 32'(run_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
